commit_trace_fifo: RTL

- Sits between the P6 `mips` core's retire-visible outputs and the trace sink: bench printer, UART dumper or compare checker.
- Captures every architectural write the core commits in a cycle:
  - GRF writes from the W stage (`w_*`),
  - data-memory stores from the M stage (`m_*`).
- Packs each write into a uniform trace record and buffers the records in a FIFO.
- Presents the records one per cycle on a valid/ready interface, so a slow consumer never has to sample the core combinationally.

---
 rtl/commit_trace_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: packs committed GRF writes and stores into trace records
// and buffers them in a FIFO behind a valid/ready interface.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_grf_we,
  input  logic [4:0]       w_grf_addr,
  input  logic [31:0]      w_grf_wdata,
  input  logic [31:0]      w_inst_addr,
  input  logic [31:0]      m_data_addr,
  input  logic [31:0]      m_data_wdata,
  input  logic [3:0]       m_data_byteen,
  input  logic [31:0]      m_inst_addr,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             rec_kind,
  output logic [31:0]      rec_pc,
  output logic [31:0]      rec_addr,
  output logic [31:0]      rec_data,
  output logic [3:0]       rec_byteen,
  output logic [CNT_W-1:0] level,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 101;
  logic [RW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d, free;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [16:0]      drop_sum;
  logic             grf_ev, st_ev, acc_grf, acc_st, pop;
  logic [1:0]       n_push, n_drop;
  logic [RW-1:0]    grf_rec, st_rec;
  assign grf_ev  = w_grf_we && (w_grf_addr != 5'd0);
  assign st_ev   = |m_data_byteen;
  assign grf_rec = {1'b0, w_inst_addr, 27'd0, w_grf_addr, w_grf_wdata, 4'hF};
  assign st_rec  = {1'b1, m_inst_addr, m_data_addr[31:2], 2'b00, m_data_wdata, m_data_byteen};
  assign rec_valid = level_q != '0;
  assign pop       = rec_valid && rec_ready;
  // a pop on this edge frees a slot for this edge's push
  assign free    = CNT_W'(DEPTH) - level_q + CNT_W'(pop);
  assign acc_grf = grf_ev && (free != '0);
  assign acc_st  = st_ev && (free >= (grf_ev ? CNT_W'(2) : CNT_W'(1)));
  assign n_push  = {1'b0, acc_grf} + {1'b0, acc_st};
  assign n_drop  = {1'b0, grf_ev & ~acc_grf} + {1'b0, st_ev & ~acc_st};
  assign level_d    = level_q + CNT_W'(n_push) - CNT_W'(pop);
  assign wr_ptr_d   = wr_ptr_q + AW'(n_push);
  assign rd_ptr_d   = rd_ptr_q + AW'(pop);
  assign drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
  assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  assign {rec_kind, rec_pc, rec_addr, rec_data, rec_byteen} = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_q | (n_drop != 2'd0);
      drop_cnt_q <= drop_cnt_d;
    end
  end
  // GRF record is older, so it takes the first free slot
  always_ff @(posedge clk) begin
    if (acc_grf || acc_st) mem_q[wr_ptr_q] <= acc_grf ? grf_rec : st_rec;
    if (acc_grf && acc_st) mem_q[wr_ptr_q + AW'(1)] <= st_rec;
  end
endmodule
